// File: rtl/cdb_pkg.sv
// Shared CDB types: result flag bundle, flag bit positions and the
// default per-channel latency table (ch0 int, ch1 ls, ch2 mult, ch3 div).
package cdb_pkg;

   typedef struct packed {
      logic store_pc;
      logic jalr;
      logic branch_taken;
      logic branch;
   } cdb_flags_t;

   localparam int FLAG_BRANCH   = 0;
   localparam int FLAG_TAKEN    = 1;
   localparam int FLAG_JALR     = 2;
   localparam int FLAG_STORE_PC = 3;

   localparam logic [15:0] CDB_CH_LAT_DEF = {4'd6, 4'd3, 4'd0, 4'd0};

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: at most one grant per conflict class per
// cycle, with a pointer update when a class collision refused someone.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int CLS_W = 4,
   parameter int PW    = $clog2(N)
) (
   input  logic [N-1:0]            req,
   input  logic [N-1:0][CLS_W-1:0] cls,
   input  logic [PW-1:0]           ptr,
   output logic [N-1:0]            gnt,
   output logic                    upd,
   output logic [PW-1:0]           ptr_nxt
);

   logic [2**CLS_W-1:0] taken;
   int                  idx;
   int                  first;

   always_comb begin
      gnt   = '0;
      taken = '0;
      upd   = 1'b0;
      first = -1;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N) idx = idx - N;
         if (req[idx]) begin
            if (taken[cls[idx]]) begin
               upd = 1'b1;
            end else begin
               gnt[idx]        = 1'b1;
               taken[cls[idx]] = 1'b1;
               if (first < 0) first = idx;
            end
         end
      end
      ptr_nxt = (first + 1 >= N) ? '0 : PW'(first + 1);
   end

endmodule

// File: rtl/cdb_issue_arbiter.sv
// Issue arbiter for the common data bus: reserves future CDB slots per
// channel latency so results never collide, and drives the CDB from slot 0.
module cdb_issue_arbiter
   import cdb_pkg::*;
#(
   parameter int                     NUM_CH = 4,
   parameter int                     TAG_W  = 6,
   parameter int                     DATA_W = 32,
   parameter int                     LAT_W  = 4,
   parameter logic [NUM_CH*LAT_W-1:0] CH_LAT = CDB_CH_LAT_DEF,
   localparam int                    OW     = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        ch_req,
   output logic [NUM_CH-1:0]        ch_grant,
   input  logic [NUM_CH*TAG_W-1:0]  ch_tag,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic [NUM_CH*4-1:0]      ch_flags,
   input  logic [NUM_CH-1:0]        ch_res_valid,
   output logic                     cdb_valid,
   output logic [TAG_W-1:0]         cdb_tag,
   output logic [DATA_W-1:0]        cdb_data,
   output cdb_flags_t               cdb_flags,
   output logic [OW-1:0]            cdb_owner,
   output logic                     sb_full
);

   localparam int MAX_LAT = 2**LAT_W - 1;

   // Latency fields are LAT_W wide, so no channel can exceed MAX_LAT.
   if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
      $error("cdb_issue_arbiter: NUM_CH must be in 2..8");
   end

   logic [MAX_LAT:1]             occ_q, occ_d;
   logic [MAX_LAT:1][OW-1:0]     own_q, own_d;
   logic                         occ0_q, occ0_d;
   logic [OW-1:0]                own0_q, own0_d;
   logic [OW-1:0]                rr_q, rr_d;

   logic [MAX_LAT:0]             cur, claim;
   logic [MAX_LAT:0][OW-1:0]     claim_own;
   logic [NUM_CH-1:0][LAT_W-1:0] lat;
   logic [NUM_CH-1:0]            elig, gnt, gnt_v;
   logic                         upd;
   logic [OW-1:0]                ptr_nxt;
   logic                         s0_v;
   logic [OW-1:0]                s0_own;

   assign cur = {occ_q, occ0_q};

   always_comb begin
      lat  = '0;
      elig = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         lat[c]  = CH_LAT[c*LAT_W +: LAT_W];
         elig[c] = ch_req[c] & ~cur[lat[c]];
      end
   end

   rr_arbiter #(
      .N     (NUM_CH),
      .CLS_W (LAT_W),
      .PW    (OW)
   ) u_arb (
      .req     (elig),
      .cls     (lat),
      .ptr     (rr_q),
      .gnt     (gnt),
      .upd     (upd),
      .ptr_nxt (ptr_nxt)
   );

   assign gnt_v    = gnt & {NUM_CH{rst}};
   assign ch_grant = gnt_v;
   assign sb_full  = rst & (&cur);

   always_comb begin
      claim     = '0;
      claim_own = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (gnt_v[c]) begin
            claim[lat[c]]     = 1'b1;
            claim_own[lat[c]] = OW'(c);
         end
      end
   end

   // Reservations age one slot per cycle; slot 1 drains into slot 0.
   always_comb begin
      occ0_d = cur[1] | claim[1];
      own0_d = cur[1] ? own_q[1] : claim_own[1];
      occ_d  = '0;
      own_d  = '0;
      for (int k = 1; k < MAX_LAT; k++) begin
         occ_d[k] = cur[k+1] | claim[k+1];
         own_d[k] = cur[k+1] ? own_q[k+1] : claim_own[k+1];
      end
      occ_d[MAX_LAT] = claim[MAX_LAT];
      own_d[MAX_LAT] = claim_own[MAX_LAT];
      rr_d = upd ? ptr_nxt : rr_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ_q  <= '0;
         own_q  <= '0;
         occ0_q <= 1'b0;
         own0_q <= '0;
         rr_q   <= '0;
      end else begin
         occ_q  <= occ_d;
         own_q  <= own_d;
         occ0_q <= occ0_d;
         own0_q <= own0_d;
         rr_q   <= rr_d;
      end
   end

   always_comb begin
      s0_v      = claim[0] | occ0_q;
      s0_own    = claim[0] ? claim_own[0] : own0_q;
      cdb_valid = 1'b0;
      cdb_tag   = '0;
      cdb_data  = '0;
      cdb_flags = '0;
      cdb_owner = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (s0_v && s0_own == OW'(c)) begin
            cdb_valid              = ch_res_valid[c];
            cdb_tag                = ch_tag[c*TAG_W +: TAG_W];
            cdb_data               = ch_data[c*DATA_W +: DATA_W];
            cdb_flags.branch       = ch_flags[c*4 + FLAG_BRANCH];
            cdb_flags.branch_taken = ch_flags[c*4 + FLAG_TAKEN];
            cdb_flags.jalr         = ch_flags[c*4 + FLAG_JALR];
            cdb_flags.store_pc     = ch_flags[c*4 + FLAG_STORE_PC];
            cdb_owner              = OW'(c);
         end
      end
   end

endmodule
